// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the ALU writeback path
// and the LSU load-return path. The ALU has fixed priority. A wait counter
// bounds LSU starvation by forcing an LSU grant. The winning write is
// registered for one cycle before it reaches the regfile write port.
module regfile_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,

  input  logic        lsu_valid_i,
  input  logic [4:0]  lsu_rd_i,
  input  logic [31:0] lsu_data_i,
  output logic        lsu_ready_o,

  output logic        rd_wren_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        forced_o
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] wait_cnt;
  logic             force_grant;

  // Grant: a starved LSU beats the ALU, otherwise the ALU wins, otherwise the LSU
  always_comb begin
    force_grant = lsu_valid_i & (wait_cnt == MAX_CNT);
    alu_ready_o = 1'b0;
    lsu_ready_o = 1'b0;
    if (force_grant) begin
      lsu_ready_o = 1'b1;
    end else if (alu_valid_i) begin
      alu_ready_o = 1'b1;
    end else if (lsu_valid_i) begin
      lsu_ready_o = 1'b1;
    end
  end

  // Count cycles a valid LSU request is refused, saturating at MAX_WAIT
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wait_cnt <= '0;
    end else if (lsu_valid_i && !lsu_ready_o) begin
      if (wait_cnt != MAX_CNT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Register the accepted write; x0 destinations are accepted but never enabled
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_wren_o <= 1'b0;
      rd_addr_o <= '0;
      rd_data_o <= '0;
      forced_o  <= 1'b0;
    end else if (alu_ready_o) begin
      rd_wren_o <= |alu_rd_i;
      rd_addr_o <= alu_rd_i;
      rd_data_o <= alu_data_i;
      forced_o  <= 1'b0;
    end else if (lsu_ready_o) begin
      rd_wren_o <= |lsu_rd_i;
      rd_addr_o <= lsu_rd_i;
      rd_data_o <= lsu_data_i;
      forced_o  <= force_grant;
    end else begin
      rd_wren_o <= 1'b0;
      forced_o  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
// Table-driven bench for the regfile writeback arbiter. Each vector carries the
// request inputs and the hand-derived ready and registered-write results. The
// registered write expected for a vector is queued when the vector is driven
// and popped when the DUT presents it one edge later.
module tb_regfile_wb_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        alu_valid_i;
  logic [4:0]  alu_rd_i;
  logic [31:0] alu_data_i;
  logic        alu_ready_o;
  logic        lsu_valid_i;
  logic [4:0]  lsu_rd_i;
  logic [31:0] lsu_data_i;
  logic        lsu_ready_o;
  logic        rd_wren_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        forced_o;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic [31:0] adata;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ldata;
    logic        exp_ar;
    logic        exp_lr;
    logic        exp_wren;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    logic        exp_forced;
  } vec_t;

  typedef struct {
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        forced;
  } wb_t;

  wb_t  exp_q[$];
  vec_t vecs[14];
  int   checks;
  int   errors;

  regfile_wb_arbiter #(.MAX_WAIT(4), .CNT_W(4)) dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .alu_valid_i(alu_valid_i),
    .alu_rd_i   (alu_rd_i),
    .alu_data_i (alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_valid_i(lsu_valid_i),
    .lsu_rd_i   (lsu_rd_i),
    .lsu_data_i (lsu_data_i),
    .lsu_ready_o(lsu_ready_o),
    .rd_wren_o  (rd_wren_o),
    .rd_addr_o  (rd_addr_o),
    .rd_data_o  (rd_data_o),
    .forced_o   (forced_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] adata,
                              logic lv, logic [4:0] lrd, logic [31:0] ldata,
                              logic ear, logic elr, logic ewren,
                              logic [4:0] eaddr, logic [31:0] edata, logic eforced);
    vec_t v;
    v.av = av;   v.ard = ard;   v.adata = adata;
    v.lv = lv;   v.lrd = lrd;   v.ldata = ldata;
    v.exp_ar = ear;   v.exp_lr = elr;
    v.exp_wren = ewren;   v.exp_addr = eaddr;
    v.exp_data = edata;   v.exp_forced = eforced;
    return v;
  endfunction

  task automatic compare(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Pop the expected registered write and compare it to the DUT write port
  task automatic checkOutput(input string tag);
    wb_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty actual=wren%0b expected=entry", tag, rd_wren_o);
      return;
    end
    e = exp_q.pop_front();
    compare({tag, ".rd_wren"},  {31'd0, rd_wren_o}, {31'd0, e.wren});
    compare({tag, ".rd_addr"},  {27'd0, rd_addr_o}, {27'd0, e.addr});
    compare({tag, ".rd_data"},  rd_data_o,          e.data);
    compare({tag, ".forced"},   {31'd0, forced_o},  {31'd0, e.forced});
  endtask

  // Drive one cycle of requests (called at posedge+1), check readys mid-cycle,
  // then check the registered write just after the next rising edge
  task automatic applyStimulus(input vec_t v, input string tag);
    wb_t e;
    alu_valid_i = v.av;  alu_rd_i = v.ard;  alu_data_i = v.adata;
    lsu_valid_i = v.lv;  lsu_rd_i = v.lrd;  lsu_data_i = v.ldata;
    e.wren = v.exp_wren;  e.addr = v.exp_addr;
    e.data = v.exp_data;  e.forced = v.exp_forced;
    exp_q.push_back(e);
    @(negedge clk_i);
    compare({tag, ".alu_ready"}, {31'd0, alu_ready_o}, {31'd0, v.exp_ar});
    compare({tag, ".lsu_ready"}, {31'd0, lsu_ready_o}, {31'd0, v.exp_lr});
    @(posedge clk_i);
    #1;
    checkOutput(tag);
  endtask

  task automatic idleInputs();
    alu_valid_i = 1'b0;  alu_rd_i = '0;  alu_data_i = '0;
    lsu_valid_i = 1'b0;  lsu_rd_i = '0;  lsu_data_i = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_i  = 1'b1;
    idleInputs();

    //           av ard  adata         lv lrd  ldata         ar lr wr addr  data          f
    vecs[0]  = mk(0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 0,    32'h0,        0);
    vecs[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,   32'h0,        1, 0, 1, 5,    32'hDEADBEEF, 0);
    vecs[2]  = mk(0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 5,    32'hDEADBEEF, 0);
    vecs[3]  = mk(1, 3,  32'h11,       1, 7,   32'h22,       1, 0, 1, 3,    32'h11,       0);
    vecs[4]  = mk(0, 0,  32'h0,        1, 7,   32'h22,       0, 1, 1, 7,    32'h22,       0);
    vecs[5]  = mk(0, 0,  32'h0,        1, 0,   32'hFFFFFFFF, 0, 1, 0, 0,    32'hFFFFFFFF, 0);
    vecs[6]  = mk(1, 1,  32'h101,      1, 9,   32'hCAFE,     1, 0, 1, 1,    32'h101,      0);
    vecs[7]  = mk(1, 2,  32'h102,      1, 9,   32'hCAFE,     1, 0, 1, 2,    32'h102,      0);
    vecs[8]  = mk(1, 3,  32'h103,      1, 9,   32'hCAFE,     1, 0, 1, 3,    32'h103,      0);
    vecs[9]  = mk(1, 4,  32'h104,      1, 9,   32'hCAFE,     1, 0, 1, 4,    32'h104,      0);
    vecs[10] = mk(1, 5,  32'h105,      1, 9,   32'hCAFE,     0, 1, 1, 9,    32'hCAFE,     1);
    vecs[11] = mk(1, 5,  32'h105,      0, 0,   32'h0,        1, 0, 1, 5,    32'h105,      0);
    vecs[12] = mk(0, 0,  32'h0,        0, 0,   32'h0,        0, 0, 0, 5,    32'h105,      0);
    vecs[13] = mk(1, 0,  32'h1234,     0, 0,   32'h0,        1, 0, 0, 0,    32'h1234,     0);

    // Reset state, then release with no requests
    repeat (2) @(posedge clk_i);
    #1;
    compare("reset.rd_wren", {31'd0, rd_wren_o}, 32'd0);
    compare("reset.rd_addr", {27'd0, rd_addr_o}, 32'd0);
    compare("reset.rd_data", rd_data_o, 32'd0);
    compare("reset.forced",  {31'd0, forced_o}, 32'd0);
    rst_i = 1'b0;

    for (int i = 0; i < 14; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Build up three LSU refusals while the ALU keeps winning
    for (int i = 0; i < 3; i++) begin
      applyStimulus(mk(1, 5'(10 + i), 32'h300 + i, 1, 9, 32'hCAFE,
                       1, 0, 1, 5'(10 + i), 32'h300 + i, 0), $sformatf("pre%0d", i));
    end

    // Reset mid-cycle drops the pending write at once
    idleInputs();
    #2;
    rst_i = 1'b1;
    #1;
    compare("midrst.rd_wren",   {31'd0, rd_wren_o},   32'd0);
    compare("midrst.forced",    {31'd0, forced_o},    32'd0);
    compare("midrst.alu_ready", {31'd0, alu_ready_o}, 32'd0);
    compare("midrst.lsu_ready", {31'd0, lsu_ready_o}, 32'd0);
    @(posedge clk_i);
    #1;
    compare("midrst.hold_wren", {31'd0, rd_wren_o}, 32'd0);
    compare("midrst.rd_addr",   {27'd0, rd_addr_o}, 32'd0);
    rst_i = 1'b0;

    // After reset the LSU must again be refused four full cycles
    for (int i = 0; i < 4; i++) begin
      applyStimulus(mk(1, 5'(20 + i), 32'h400 + i, 1, 9, 32'hCAFE,
                       1, 0, 1, 5'(20 + i), 32'h400 + i, 0), $sformatf("post%0d", i));
    end
    applyStimulus(mk(1, 24, 32'h404, 1, 9, 32'hCAFE, 0, 1, 1, 9, 32'hCAFE, 1), "post4");
    applyStimulus(mk(1, 24, 32'h404, 0, 0, 32'h0,    1, 0, 1, 24, 32'h404, 0), "post5");
    idleInputs();
    applyStimulus(mk(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 0, 24, 32'h404, 0), "post6");

    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_leftover actual=%0d expected=0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
